// File: rtl/seq_step_ctrl.sv
// Programmable step sequencer for the four-sensor gesture path: walks a table of
// masked input patterns, enforcing a per-step dwell timeout, and reports progress.
`timescale 1ns/1ps
module seq_step_ctrl #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1000,
  parameter int TW      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i1,
  input  logic       i2,
  input  logic       i3,
  input  logic       i4,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [3:0] cfg_mask,
  input  logic [3:0] cfg_val,
  input  logic       cfg_len_we,
  input  logic [4:0] cfg_len,
  input  logic       arm,
  input  logic       abort,
  output logic       busy,
  output logic [4:0] step,
  output logic       done,
  output logic       fail,
  output logic [7:0] done_cnt
);

  typedef enum logic {IDLE, MATCH} state_t;

  localparam logic [4:0]    MAX_LEN  = 5'(DEPTH);
  localparam logic [TW-1:0] TIMER_MX = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [4:0]    step_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    len_q, len_d;
  logic          done_d, fail_d;
  logic [7:0]    cnt_d;
  logic [3:0]    mask_q [DEPTH];
  logic [3:0]    val_q  [DEPTH];

  logic [3:0] pat;
  logic [3:0] cur_idx, prev_idx;
  logic       cur_match, prev_match, tbl_we;

  assign pat      = {i4, i3, i2, i1};
  assign cur_idx  = step[3:0];
  assign prev_idx = cur_idx - 4'd1;

  // Only the care bits take part in the compare, so a zero mask always matches.
  assign cur_match  = ((pat ^ val_q[cur_idx])  & mask_q[cur_idx])  == 4'd0;
  assign prev_match = ((pat ^ val_q[prev_idx]) & mask_q[prev_idx]) == 4'd0;

  assign tbl_we = (state_q == IDLE) && cfg_we;
  assign busy   = (state_q == MATCH);

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step;
    timer_d = timer_q;
    len_d   = len_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    cnt_d   = done_cnt;
    unique case (state_q)
      IDLE: begin
        if (cfg_len_we) len_d = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
        if (arm && (len_q != 5'd0) && !cfg_we && !cfg_len_we) begin
          state_d = MATCH;
          step_d  = 5'd0;
          timer_d = '0;
        end
      end
      MATCH: begin
        if (abort) begin
          state_d = IDLE;
          step_d  = 5'd0;
          timer_d = '0;
        end else if (cur_match) begin
          timer_d = '0;
          if ((step + 5'd1) == len_q) begin
            done_d  = 1'b1;
            cnt_d   = done_cnt + 8'd1;
            state_d = IDLE;
            step_d  = 5'd0;
          end else begin
            step_d = step + 5'd1;
          end
        end else if (step == 5'd0) begin
          timer_d = '0;
        end else if (prev_match) begin
          // Still holding the previous pattern: tolerated until the dwell limit.
          if (timer_q == TIMER_MX) begin
            fail_d  = 1'b1;
            step_d  = 5'd0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          fail_d  = 1'b1;
          step_d  = 5'd0;
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step     <= 5'd0;
      timer_q  <= '0;
      len_q    <= 5'd0;
      done     <= 1'b0;
      fail     <= 1'b0;
      done_cnt <= 8'd0;
    end else begin
      state_q  <= state_d;
      step     <= step_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      done     <= done_d;
      fail     <= fail_d;
      done_cnt <= cnt_d;
    end
  end

  // NOTE: the table is a small register file that must read as all-zero masks
  // after reset, so unlike a RAM it is explicitly cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mask_q[k] <= 4'd0;
        val_q[k]  <= 4'd0;
      end
    end else if (tbl_we) begin
      mask_q[cfg_addr] <= cfg_mask;
      val_q[cfg_addr]  <= cfg_val;
    end
  end

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Self-checking bench for seq_step_ctrl: expectations are queued as each cycle's
// stimulus is applied and compared against the registered outputs after the edge.
`timescale 1ns/1ps
module tb_seq_step_ctrl;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       i1, i2, i3, i4;
  logic [3:0] pat;
  logic       cfg_we, cfg_len_we, arm, abort;
  logic [3:0] cfg_addr, cfg_mask, cfg_val;
  logic [4:0] cfg_len;
  logic       busy, done, fail;
  logic [4:0] step;
  logic [7:0] done_cnt;

  assign {i4, i3, i2, i1} = pat;

  seq_step_ctrl #(.DEPTH(16), .TIMEOUT(TO), .TW(16)) dut (
    .clk(clk), .reset(reset),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_val(cfg_val),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
    .arm(arm), .abort(abort),
    .busy(busy), .step(step), .done(done), .fail(fail), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] step;
    logic       busy;
    logic       done;
    logic       fail;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_cnt  = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: queue the expected post-edge outputs, then compare after the edge.
  task automatic tick(input string tag, input logic [4:0] st, input logic b,
                      input logic d, input logic f);
    exp_t e;
    if (d) exp_cnt++;
    e.tag = tag; e.step = st; e.busy = b; e.done = d; e.fail = f; e.cnt = exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".step"}, 32'(step), 32'(e.step));
    check({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({e.tag, ".done"}, 32'(done), 32'(e.done));
    check({e.tag, ".fail"}, 32'(fail), 32'(e.fail));
    check({e.tag, ".cnt"},  32'(done_cnt), 32'(e.cnt));
    @(negedge clk);
    arm = 1'b0; abort = 1'b0; cfg_we = 1'b0; cfg_len_we = 1'b0;
  endtask

  task automatic do_reset();
    exp_cnt = 8'd0;
    reset   = 1'b1;
    tick("reset", 5'd0, 1'b0, 1'b0, 1'b0);
    reset   = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [3:0] m, input logic [3:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_mask = m; cfg_val = v;
    tick("cfg_wr", 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_len(input logic [4:0] l);
    cfg_len_we = 1'b1; cfg_len = l;
    tick("cfg_len", 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Full pass through the three-entry gesture table.
  task automatic run3(input string tag);
    arm = 1'b1; pat = 4'b0000;
    tick({tag, ".arm"}, 5'd0, 1'b1, 1'b0, 1'b0);
    tick({tag, ".wait"}, 5'd0, 1'b1, 1'b0, 1'b0);
    pat = 4'b0100; tick({tag, ".s1"}, 5'd1, 1'b1, 1'b0, 1'b0);
    pat = 4'b1001; tick({tag, ".s2"}, 5'd2, 1'b1, 1'b0, 1'b0);
    pat = 4'b0000; tick({tag, ".done"}, 5'd0, 1'b0, 1'b1, 1'b0);
    tick({tag, ".idle"}, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pat = 4'b0000; arm = 1'b0; abort = 1'b0;
    cfg_we = 1'b0; cfg_len_we = 1'b0; cfg_addr = 4'd0; cfg_mask = 4'd0;
    cfg_val = 4'd0; cfg_len = 5'd0;

    do_reset();
    arm = 1'b1; tick("arm_len0", 5'd0, 1'b0, 1'b0, 1'b0);

    write_entry(4'd0, 4'b0100, 4'b0100);
    write_entry(4'd1, 4'b1001, 4'b1001);
    write_entry(4'd2, 4'b0100, 4'b0000);
    set_len(5'd3);

    run3("seq1");

    // Mismatch at step 1 fails and re-arms at step 0.
    arm = 1'b1; pat = 4'b0000; tick("mm.arm", 5'd0, 1'b1, 1'b0, 1'b0);
    pat = 4'b0100; tick("mm.s1", 5'd1, 1'b1, 1'b0, 1'b0);
    pat = 4'b0010; tick("mm.fail", 5'd0, 1'b1, 1'b0, 1'b1);
    pat = 4'b0000; tick("mm.wait", 5'd0, 1'b1, 1'b0, 1'b0);

    // Holding the step-0 pattern at step 1 times out on the TO-th cycle.
    pat = 4'b0100; tick("to.s1", 5'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++) tick($sformatf("to.hold%0d", k), 5'd1, 1'b1, 1'b0, 1'b0);
    tick("to.fail", 5'd0, 1'b1, 1'b0, 1'b1);

    // Advance on the last allowed cycle wins over the timeout.
    tick("late.s1", 5'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++) tick($sformatf("late.hold%0d", k), 5'd1, 1'b1, 1'b0, 1'b0);
    pat = 4'b1001; tick("late.adv", 5'd2, 1'b1, 1'b0, 1'b0);
    pat = 4'b0000; tick("late.done", 5'd0, 1'b0, 1'b1, 1'b0);

    // Config writes in MATCH are dropped; abort leaves without a pulse.
    arm = 1'b1; tick("cm.arm", 5'd0, 1'b1, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_mask = 4'b0100; cfg_val = 4'b0000;
    cfg_len_we = 1'b1; cfg_len = 5'd1;
    tick("cm.write", 5'd0, 1'b1, 1'b0, 1'b0);
    tick("cm.e0_kept", 5'd0, 1'b1, 1'b0, 1'b0);
    pat = 4'b0100; tick("cm.len_kept", 5'd1, 1'b1, 1'b0, 1'b0);
    pat = 4'b1001; tick("cm.s2", 5'd2, 1'b1, 1'b0, 1'b0);
    pat = 4'b0000; abort = 1'b1; tick("abort", 5'd0, 1'b0, 1'b0, 1'b0);
    tick("abort.idle", 5'd0, 1'b0, 1'b0, 1'b0);
    run3("rerun");

    // Arm is ignored when a config write happens in the same cycle.
    arm = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_mask = 4'b0100; cfg_val = 4'b0100;
    tick("arm_cfg", 5'd0, 1'b0, 1'b0, 1'b0);
    arm = 1'b1; cfg_len_we = 1'b1; cfg_len = 5'd3;
    tick("arm_len_we", 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-sequence clears outputs, length and table.
    arm = 1'b1; tick("rst.arm", 5'd0, 1'b1, 1'b0, 1'b0);
    pat = 4'b0100; tick("rst.s1", 5'd1, 1'b1, 1'b0, 1'b0);
    do_reset();
    arm = 1'b1; tick("rst.arm_len0", 5'd0, 1'b0, 1'b0, 1'b0);
    pat = 4'b0000;
    set_len(5'd1);
    arm = 1'b1; tick("clr.arm", 5'd0, 1'b1, 1'b0, 1'b0);
    tick("clr.done", 5'd0, 1'b0, 1'b1, 1'b0);

    // Length above the table depth clamps to 16 steps.
    set_len(5'd20);
    arm = 1'b1; tick("clamp.arm", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 16; k++) tick($sformatf("clamp.s%0d", k), 5'(k), 1'b1, 1'b0, 1'b0);
    tick("clamp.done", 5'd0, 1'b0, 1'b1, 1'b0);

    // Completion counter wraps after 256 sequences.
    set_len(5'd1);
    for (int n = 0; n < 254; n++) begin
      arm = 1'b1; tick("wrap.arm", 5'd0, 1'b1, 1'b0, 1'b0);
      tick("wrap.done", 5'd0, 1'b0, 1'b1, 1'b0);
    end
    check("wrap.zero", 32'(done_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
